// File: rtl/axioma_uart_rx_sampler.sv
// Oversampling UART receive front-end: pin synchroniser, baud prescaler, 3-sample majority
// bit decision, frame FSM and a 2-entry receive FIFO with FE/UPE/DOR status.
module axioma_uart_rx_sampler #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        rxd_in_i,
  input  logic        rx_en_i,
  input  logic [11:0] ubrr_i,
  input  logic        u2x_i,
  input  logic [2:0]  ucsz_i,
  input  logic [1:0]  upm_i,
  input  logic        rd_pop_i,
  output logic [7:0]  rx_data_o,
  output logic        rx_fe_o,
  output logic        rx_upe_o,
  output logic        rx_dor_o,
  output logic        rx_avail_o,
  output logic        rx_busy_o,
  output logic [7:0]  debug_state_o
);

  typedef enum logic [2:0] {
    StIdle   = 3'd0,
    StStart  = 3'd1,
    StData   = 3'd2,
    StParity = 3'd3,
    StStop   = 3'd4
  } state_e;

  state_e state_q, state_d;

  logic [SYNC_STAGES-1:0] sync_q;
  logic [11:0]            presc_q, presc_d;
  logic [3:0]             phase_q, phase_d;
  logic [2:0]             bit_idx_q, bit_idx_d;
  logic [7:0]             data_q, data_d;
  logic [1:0]             samp_q, samp_d;
  logic                   upe_q, upe_d;
  logic                   os8_q, os8_d;
  logic [2:0]             nbits_q, nbits_d;
  logic                   par_en_q, par_en_d;
  logic                   par_odd_q, par_odd_d;

  logic [1:0][9:0]        mem_q, mem_d;
  logic                   rd_ptr_q, rd_ptr_d;
  logic [1:0]             count_q, count_d;
  logic                   dor_q, dor_d;

  logic       rxs, tick, wrap, decide, maj;
  logic [3:0] samp_base, last_phase;
  logic       push, push_fe;

  assign rxs        = sync_q[SYNC_STAGES-1];
  assign tick       = (presc_q == 12'd0);
  assign samp_base  = os8_q ? 4'd3 : 4'd7;
  assign last_phase = os8_q ? 4'd7 : 4'd15;
  assign wrap       = tick && (phase_q == last_phase);
  assign decide     = tick && (phase_q == samp_base + 4'd2);
  assign maj        = (samp_q[0] & samp_q[1]) | (samp_q[0] & rxs) | (samp_q[1] & rxs);

  always_comb begin
    state_d   = state_q;
    phase_d   = phase_q;
    bit_idx_d = bit_idx_q;
    data_d    = data_q;
    samp_d    = samp_q;
    upe_d     = upe_q;
    os8_d     = os8_q;
    nbits_d   = nbits_q;
    par_en_d  = par_en_q;
    par_odd_d = par_odd_q;
    presc_d   = tick ? ubrr_i : presc_q - 12'd1;
    push      = 1'b0;
    push_fe   = 1'b0;

    if (state_q != StIdle && tick) begin
      phase_d = wrap ? 4'd0 : phase_q + 4'd1;
    end
    if (tick && phase_q == samp_base) samp_d[0] = rxs;
    if (tick && phase_q == samp_base + 4'd1) samp_d[1] = rxs;

    unique case (state_q)
      StIdle: begin
        if (rx_en_i && !rxs) begin
          state_d   = StStart;
          presc_d   = ubrr_i;
          phase_d   = 4'd0;
          bit_idx_d = 3'd0;
          data_d    = 8'd0;
          upe_d     = 1'b0;
          os8_d     = u2x_i;
          // Stored as N-1; ucsz 4..7 behave as 8-bit characters.
          nbits_d   = ucsz_i[2] ? 3'd7 : 3'd4 + {1'b0, ucsz_i[1:0]};
          par_en_d  = upm_i[1];
          par_odd_d = upm_i[0];
        end
      end
      StStart: begin
        if (decide && maj) begin
          state_d = StIdle;
        end else if (wrap) begin
          state_d   = StData;
          bit_idx_d = 3'd0;
        end
      end
      StData: begin
        if (decide) data_d[bit_idx_q] = maj;
        if (wrap) begin
          if (bit_idx_q == nbits_q) begin
            state_d = par_en_q ? StParity : StStop;
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end
      end
      StParity: begin
        if (decide) upe_d = maj ^ (^data_q) ^ par_odd_q;
        if (wrap) state_d = StStop;
      end
      StStop: begin
        // Leave mid stop bit so the next start edge is not missed.
        if (decide) begin
          push    = 1'b1;
          push_fe = ~maj;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    if (!rx_en_i) state_d = StIdle;
  end

  logic       pop_eff, push_ok, wr_idx;
  logic [1:0] cnt_after_pop;

  always_comb begin
    pop_eff       = rd_pop_i && (count_q != 2'd0);
    cnt_after_pop = count_q - {1'b0, pop_eff};
    // Pop is applied before push, so a pop in the same cycle frees a slot.
    push_ok       = push && (cnt_after_pop != 2'd2);
    wr_idx        = rd_ptr_q ^ count_q[0];
    mem_d         = mem_q;
    if (push_ok) mem_d[wr_idx] = {push_fe, upe_q, data_q};
    rd_ptr_d = rd_ptr_q ^ pop_eff;
    count_d  = cnt_after_pop + {1'b0, push_ok};
    dor_d    = dor_q;
    if (rd_pop_i) dor_d = 1'b0;
    if (push && !push_ok) dor_d = 1'b1;
    if (!rx_en_i) begin
      rd_ptr_d = 1'b0;
      count_d  = 2'd0;
      dor_d    = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q    <= '1;
      state_q   <= StIdle;
      presc_q   <= 12'd0;
      phase_q   <= 4'd0;
      bit_idx_q <= 3'd0;
      data_q    <= 8'd0;
      samp_q    <= 2'b11;
      upe_q     <= 1'b0;
      os8_q     <= 1'b0;
      nbits_q   <= 3'd7;
      par_en_q  <= 1'b0;
      par_odd_q <= 1'b0;
      mem_q     <= '0;
      rd_ptr_q  <= 1'b0;
      count_q   <= 2'd0;
      dor_q     <= 1'b0;
    end else begin
      sync_q    <= {sync_q[SYNC_STAGES-2:0], rxd_in_i};
      state_q   <= state_d;
      presc_q   <= presc_d;
      phase_q   <= phase_d;
      bit_idx_q <= bit_idx_d;
      data_q    <= data_d;
      samp_q    <= samp_d;
      upe_q     <= upe_d;
      os8_q     <= os8_d;
      nbits_q   <= nbits_d;
      par_en_q  <= par_en_d;
      par_odd_q <= par_odd_d;
      mem_q     <= mem_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      dor_q     <= dor_d;
    end
  end

  logic [9:0] head;
  assign head          = mem_q[rd_ptr_q];
  assign rx_avail_o    = (count_q != 2'd0);
  assign rx_data_o     = rx_avail_o ? head[7:0] : 8'd0;
  assign rx_upe_o      = rx_avail_o & head[8];
  assign rx_fe_o       = rx_avail_o & head[9];
  assign rx_dor_o      = dor_q;
  assign rx_busy_o     = (state_q != StIdle);
  assign debug_state_o = {state_q, count_q, bit_idx_q};

endmodule
